// File: rtl/mult_sequencer_if.sv
// Request/response bundle between the execute-stage control FSM and the
// iterative Booth multiplier.
// Ports: start/M/Q0 request from the master; ready/busy/done status and the
// HIGH/LOW product words returned by the slave (the multiplier).
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Q0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] LOW;
  logic [WIDTH-1:0] HIGH;

  modport master (
    output start, M, Q0,
    input  ready, busy, done, LOW, HIGH
  );

  modport slave (
    input  start, M, Q0,
    output ready, busy, done, LOW, HIGH
  );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative signed WIDTH x WIDTH radix-2 Booth multiplier, one add/sub-and-shift step per clock.
// Latency: start accepted at edge E0, WIDTH steps on E1..E_WIDTH, done pulses in the following cycle (33 cycles for WIDTH=32).
// Backpressure: start is only accepted while ready=1 (IDLE or DONE); start during RUN is ignored.
// Ports: clk/rst (async active-high); bus.slave carries start/M/Q0 in and
// ready/busy/done plus the product as HIGH (upper word) and LOW (lower word).
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic            clk,
  input logic            rst,
  mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] M_reg;
  logic [WIDTH-1:0] AC;
  logic [WIDTH-1:0] Q;
  logic             q_1;
  logic [CNT_W-1:0] count;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;

  // Sign-extended add/sub. The extra bit keeps AC - M correct when
  // M = -2^(WIDTH-1), where a WIDTH-bit subtract would wrap.
  logic [WIDTH:0] ac_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    ac_ext = {AC[WIDTH-1], AC};
    m_ext  = {M_reg[WIDTH-1], M_reg};
    sum    = ac_ext;
    case ({Q[0], q_1})
      2'b10:   sum = ac_ext - m_ext;
      2'b01:   sum = ac_ext + m_ext;
      default: sum = ac_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      M_reg   <= '0;
      AC      <= '0;
      Q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // Arithmetic right shift of {sum, Q}: sum[0] drops into Q's MSB.
          AC    <= sum[WIDTH:1];
          Q     <= {sum[0], Q[WIDTH-1:1]};
          q_1   <= Q[0];
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state   <= DONE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end
        end

        // IDLE and DONE accept a new operation identically, so a start held
        // high in DONE chains the next product with no idle bubble.
        default: begin
          done_r <= 1'b0;
          if (bus.start) begin
            M_reg   <= bus.M;
            Q       <= bus.Q0;
            AC      <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            state   <= RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            // Product registers are left alone so HIGH/LOW stay valid in IDLE.
            state   <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.HIGH  = AC;
  assign bus.LOW   = Q;

endmodule
